sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_pkg.sv | 31 +++
 rtl/sha256_k_rom.sv | 31 +++
 rtl/sha256_msg_schedule.sv | 138 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message schedule and round datapath.
// Contents:
//   NUM_ROUNDS, BLK_WORDS : block geometry (64 rounds, 16 input words)
//   state_t               : schedule FSM encoding
//   rotr, sig0, sig1      : rotate-right and the two small-sigma functions
package sha256_pkg;

  localparam int NUM_ROUNDS = 64;
  localparam int BLK_WORDS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Shifting left by 32 when n == 0 yields zero, so rotr(x, 0) == x.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round constant ROM, purely combinational.
// Ports:
//   addr : round index t (0..63)
//   k    : K[t]
module sha256_k_rom (
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  assign k = K_TAB[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block as 16 words and streams
// W[t]/K[t] for t = 0..63 to the round datapath using a 16-word sliding window.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   start                  : begin a new block (honoured only in IDLE)
//   word_in/word_valid     : message words, W[0] first
//   word_ready             : high while loading
//   w_out/k_out/round      : current round outputs, qualified by w_valid
//   out_ready              : downstream consumes the current round
//   done                   : one-cycle pulse after round 63 is consumed
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | shifting 16 message words into the window
// RUN   | emitting W[round]/K[round], expanding one word per handshake
// DONE  | one-cycle done pulse, then back to IDLE
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic [5:0]  round,
  output logic        w_valid,
  input  logic        out_ready,
  output logic        done
);

  localparam logic [4:0] LAST_WORD  = 5'(BLK_WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  round_q, round_d;
  logic [31:0] win_q [BLK_WORDS];
  logic [31:0] win_d [BLK_WORDS];
  logic [31:0] w_new;
  logic        load_fire;
  logic        run_fire;

  assign load_fire = (state_q == ST_LOAD) && word_valid;
  assign run_fire  = (state_q == ST_RUN) && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (load_fire && (cnt_q == LAST_WORD)) state_d = ST_RUN;
      ST_RUN:  if (run_fire && (round_q == LAST_ROUND)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    word_ready = 1'b0;
    w_valid    = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_LOAD: word_ready = 1'b1;
      ST_RUN:  w_valid    = 1'b1;
      ST_DONE: done       = 1'b1;
      default: ;
    endcase
  end

  // Window and counters. Loading and expansion share one shift path; only the
  // word entering win[15] differs. Since a load always writes all 16 slots, no
  // content from a previous block survives into the next one.
  always_comb begin
    cnt_d   = cnt_q;
    round_d = round_q;
    win_d   = win_q;
    w_new   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    if ((state_q == ST_IDLE) && start) begin
      cnt_d = '0;
    end

    if (load_fire) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST_WORD) begin
        round_d = '0;
      end
    end

    if (load_fire || run_fire) begin
      for (int i = 0; i < BLK_WORDS - 1; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[BLK_WORDS - 1] = load_fire ? word_in : w_new;
    end

    // Wraps 63 -> 0 on the final handshake.
    if (run_fire) begin
      round_d = round_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      round_q <= '0;
      for (int i = 0; i < BLK_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      round_q <= round_d;
      win_q   <= win_d;
    end
  end

  assign w_out = win_q[0];
  assign round = round_q;

  sha256_k_rom u_k_rom (
    .addr (round_q),
    .k    (k_out)
  );

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] w_out;
  logic [31:0] k_out;
  logic [5:0]  round;
  logic        w_valid;
  logic        out_ready;
  logic        done;

  sha256_msg_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .w_out      (w_out),
    .k_out      (k_out),
    .round      (round),
    .w_valid    (w_valid),
    .out_ready  (out_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [69:0] sb_q [$];
  logic [69:0] sb_e;
  logic [31:0] blk [16];
  logic [31:0] obs_w [64];
  logic [31:0] obs_k63;
  bit          bp_mode = 1'b0;
  int          done_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_w, prev_k;
  logic [5:0]  prev_r;
  int          cyc;

  logic [31:0] k_ref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] bs0(input logic [31:0] x);
    bs0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    bs1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference expansion of blk[], pushed as {round, W, K} per round.
  task automatic push_expected();
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++) w[i] = bs1(w[i-2]) + w[i-7] + bs0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) sb_q.push_back({6'(i), w[i], k_ref[i]});
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  // Out_ready source: random under backpressure, otherwise always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop on each handshake, hold check while stalled.
  always @(negedge clk) begin
    if (rst_n && w_valid) begin
      if (prev_stall) begin
        check("hold_w", w_out, prev_w);
        check("hold_k", k_out, prev_k);
        check("hold_round", 32'(round), 32'(prev_r));
      end
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_e = sb_q.pop_front();
          check("round", 32'(round), 32'(sb_e[69:64]));
          check("w_out", w_out, sb_e[63:32]);
          check("k_out", k_out, sb_e[31:0]);
          obs_w[round] = w_out;
          if (round == 6'd63) obs_k63 = k_out;
        end
      end
      prev_stall = !out_ready;
      prev_w     = w_out;
      prev_k     = k_out;
      prev_r     = round;
    end else begin
      prev_stall = 1'b0;
    end
    if (rst_n && done) done_seen++;
  end

  // gap_at: index of the word preceded by a 3-cycle valid gap (-1: none)
  // rst_at: round at which reset is applied mid-RUN (-1: none)
  // noise : toggle start during LOAD/RUN and assert it in DONE
  task automatic run_block(input int gap_at, input int rst_at, input bit noise, output int cycles);
    int  d0;
    bit  aborted;
    aborted = 1'b0;
    for (int i = 0; i < 64; i++) obs_w[i] = 32'hdeadbeef;
    obs_k63 = '0;
    check("idle_ready", 32'(word_ready), 32'd0);
    push_expected();
    d0     = done_seen;
    cycles = 0;
    start  = 1'b1;
    tick(); cycles++;
    start  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          word_valid = 1'b0;
          word_in    = $urandom;
          if (noise) start = 1'b1;
          tick(); cycles++;
          check("gap_ready", 32'(word_ready), 32'd1);
        end
      end
      check("word_ready", 32'(word_ready), 32'd1);
      word_valid = 1'b1;
      word_in    = blk[i];
      start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(); cycles++;
    end
    word_valid = 1'b0;
    word_in    = '0;
    start      = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (rst_at >= 0 && w_valid && round == 6'(rst_at)) begin
        rst_n = 1'b0;
        tick();
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_w_out", w_out, 32'd0);
        check("rst_word_ready", 32'(word_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        sb_q.delete();
        aborted = 1'b1;
        break;
      end
      if (noise) start = 1'($urandom_range(0, 1));
      tick(); cycles++;
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_seen", 32'(done), 32'd1);
      check("done_w_valid", 32'(w_valid), 32'd0);
      start = noise;
      tick();
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      check("done_pulses", 32'(done_seen - d0), 32'd1);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      if (noise) begin
        tick();
        check("done_start_ignored", 32'(word_ready), 32'd0);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    word_in    = '0;
    repeat (3) tick();
    check("rst_state_ready", 32'(word_ready), 32'd0);
    check("rst_state_valid", 32'(w_valid), 32'd0);
    check("rst_state_done", 32'(done), 32'd0);
    check("rst_state_w", w_out, 32'd0);
    check("rst_state_k", k_out, 32'h428a2f98);
    check("rst_state_round", 32'(round), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_valid", 32'(w_valid), 32'd0);

    // "abc" block, no stalls
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    run_block(-1, -1, 1'b0, cyc);
    check("abc_cycles", 32'(cyc), 32'd81);
    check("abc_w0", obs_w[0], 32'h61626380);
    check("abc_w15", obs_w[15], 32'h00000018);
    check("abc_w16", obs_w[16], 32'h61626380);
    check("abc_w17", obs_w[17], 32'h000f0000);
    check("abc_k63", obs_k63, 32'hc67178f2);

    // Same random block unstalled, then under backpressure
    random_block();
    run_block(-1, -1, 1'b0, cyc);
    bp_mode = 1'b1;
    run_block(-1, -1, 1'b0, cyc);
    bp_mode = 1'b0;
    tick();

    // Bursty load: gap before the 9th word
    random_block();
    run_block(8, -1, 1'b0, cyc);
    check("burst_w8", obs_w[8], blk[8]);
    check("burst_w7", obs_w[7], blk[7]);

    // Reset mid-RUN, then a clean block
    random_block();
    run_block(-1, 30, 1'b0, cyc);
    random_block();
    run_block(-1, -1, 1'b0, cyc);

    // start noise in LOAD/RUN/DONE, with backpressure
    bp_mode = 1'b1;
    random_block();
    run_block(-1, -1, 1'b1, cyc);
    bp_mode = 1'b0;

    // Back-to-back blocks: next start the cycle after done
    random_block();
    run_block(-1, -1, 1'b0, cyc);
    random_block();
    run_block(-1, -1, 1'b0, cyc);

    check("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
